serial_write_arbiter: RTL

Controller that shares one serial write buffer (BUF_SIZE-bit shift-out buffer with start / write_count / done handshake) between two requesters, e.g. the MITM forward path (req 0) and the injection path (req 1). It arbitrates, latches the winner's data and bit count, sequences the buffer through start → busy → done, and returns a per-requester acknowledge and completion pulse. It contains no shift logic; it drives the buffer's control inputs and observes its done output.

---
 rtl/serial_write_arbiter.sv | 123 ++++++++++++
 1 files changed

// File: rtl/serial_write_arbiter.sv
// Arbitrates two requesters onto one serial write buffer and sequences it start -> busy -> done.
// Optional ROUND_ROBIN_EN: alternate grants under contention instead of fixed priority to req0.
module serial_write_arbiter #(
    parameter int BUF_SIZE   = 8,
    parameter int COUNT_SIZE = $clog2(BUF_SIZE + 1)
) (
    input  logic                  sys_clk,
    input  logic                  rst,
    input  logic                  req0,
    input  logic [BUF_SIZE-1:0]   data0,
    input  logic [COUNT_SIZE-1:0] count0,
    input  logic                  req1,
    input  logic [BUF_SIZE-1:0]   data1,
    input  logic [COUNT_SIZE-1:0] count1,
    output logic                  ack0,
    output logic                  ack1,
    output logic                  done0,
    output logic                  done1,
    output logic                  busy,
    output logic                  owner,
    output logic                  buf_start,
    output logic [BUF_SIZE-1:0]   buf_data,
    output logic [COUNT_SIZE-1:0] buf_count,
    input  logic                  buf_done
);

    typedef enum logic [2:0] {IDLE, START, ARM, WAIT, FIN} state_t;

    localparam logic [COUNT_SIZE-1:0] MAX_CNT = COUNT_SIZE'(BUF_SIZE);

    state_t                  state_q;
    logic                    ack0_q, ack1_q, done0_q, done1_q;
    logic                    busy_q, owner_q, start_q;
    logic [BUF_SIZE-1:0]     data_q;
    logic [COUNT_SIZE-1:0]   count_q;

    logic                    win_d;
    logic [BUF_SIZE-1:0]     data_d;
    logic [COUNT_SIZE-1:0]   cnt_raw, count_d;

`ifdef ROUND_ROBIN_EN
    logic rr_q;

    // rr_q names the requester preferred when both are asking.
    always_comb win_d = req0 ? (req1 & rr_q) : 1'b1;

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst)
            rr_q <= 1'b0;
        else if (state_q == IDLE && (req0 || req1))
            rr_q <= ~win_d;
    end
`else
    always_comb win_d = ~req0;
`endif

    always_comb begin
        data_d  = win_d ? data1 : data0;
        cnt_raw = win_d ? count1 : count0;
        count_d = (cnt_raw > MAX_CNT) ? MAX_CNT : cnt_raw;
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            busy_q  <= 1'b0;
            owner_q <= 1'b0;
            start_q <= 1'b0;
            data_q  <= '0;
            count_q <= '0;
        end else begin
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            start_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req0 || req1) begin
                        ack0_q  <= ~win_d;
                        ack1_q  <= win_d;
                        owner_q <= win_d;
                        data_q  <= data_d;
                        count_q <= count_d;
                        busy_q  <= 1'b1;
                        // Zero-length transfers never touch the buffer.
                        state_q <= (count_d == '0) ? FIN : START;
                    end else begin
                        busy_q  <= 1'b0;
                    end
                end
                START: begin
                    start_q <= 1'b1;
                    state_q <= ARM;
                end
                // Guard cycle: buffer still shows its old done level here.
                ARM:  state_q <= WAIT;
                WAIT: if (buf_done) state_q <= FIN;
                FIN: begin
                    done0_q <= ~owner_q;
                    done1_q <= owner_q;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ack0      = ack0_q;
    assign ack1      = ack1_q;
    assign done0     = done0_q;
    assign done1     = done1_q;
    assign busy      = busy_q;
    assign owner     = owner_q;
    assign buf_start = start_q;
    assign buf_data  = data_q;
    assign buf_count = count_q;

endmodule
